// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the idle-driven clock-gate controller.
// The state encoding is fixed so it can be read directly in waveforms.
package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      IDLE = 2'd1,
      OFF  = 2'd2,
      WAKE = 2'd3
   } state_t;

   localparam int DEF_IDLE_W   = 8;
   localparam int DEF_WAKE_CYC = 2;
   localparam int MIN_CNT_W    = 4;

   // The wake count (up to 14) must always fit, even with a narrow idle threshold.
   function automatic int cnt_width(input int idle_w);
      return (idle_w > MIN_CNT_W) ? idle_w : MIN_CNT_W;
   endfunction

endpackage

// File: rtl/clk_gate_ctrl_cnt.sv
// Loadable down-counter shared by the idle-timeout and wake-delay phases.
// A load takes priority over a decrement, and the count holds at zero.
module clk_gate_ctrl_cnt #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: turns the gated domain's clock off after a run of idle
// cycles and brings it back with a fixed settle delay before accepting requests.
module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int IDLE_W   = DEF_IDLE_W,
   parameter int WAKE_CYC = DEF_WAKE_CYC
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en_cfg,
   input  logic [IDLE_W-1:0] idle_thr,
   input  logic              test_en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              busy,
   output logic              gate_en,
   output logic              gated
);

   localparam int CNT_W = cnt_width(IDLE_W);

   state_t           state_q;
   state_t           state_d;
   logic             gate_en_q;
   logic             gate_en_d;
   logic             gated_q;
   logic             gated_d;
   logic             idle_cyc;
   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_zero;

   assign idle_cyc = !req_valid && !busy && en_cfg && !test_en;

   clk_gate_ctrl_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= RUN;
         gate_en_q <= 1'b1;
         gated_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gate_en_q <= gate_en_d;
         gated_q   <= gated_d;
      end
   end

   // idle_thr is only sampled on the RUN->IDLE load, so mid-count changes wait.
   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = CNT_W'(idle_thr);
      case (state_q)
         RUN: begin
            if (idle_cyc) begin
               state_d  = IDLE;
               cnt_load = 1'b1;
            end
         end
         IDLE: begin
            if (!idle_cyc) begin
               state_d = RUN;
            end else if (cnt_zero) begin
               state_d = OFF;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         OFF: begin
            if (!idle_cyc) begin
               state_d      = WAKE;
               cnt_load     = 1'b1;
               cnt_load_val = CNT_W'(WAKE_CYC - 1);
            end
         end
         WAKE: begin
            if (cnt_zero) begin
               state_d = RUN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Gate enable is registered from the next state so the cell sees a clean flop output.
   always_comb begin
      req_ready = (state_q == RUN) || (state_q == IDLE);
      gate_en_d = (state_d != OFF);
      gated_d   = (state_d == OFF);
   end

   assign gate_en = gate_en_q;
   assign gated   = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: the driver queues hand-computed outputs for
// each cycle and a negedge monitor pops and compares them.
module tb_clk_gate_ctrl;

   logic       clock;
   logic       reset;
   logic       en_cfg;
   logic [7:0] idle_thr;
   logic       test_en;
   logic       req_valid;
   logic       req_ready;
   logic       busy;
   logic       gate_en;
   logic       gated;

   typedef struct packed {
      logic        exp_gate;
      logic        exp_ready;
      logic [15:0] vec_id;
   } exp_t;

   exp_t       exp_q[$];
   int         checks;
   int         errors;
   int         vec_id;
   logic [7:0] thr_v;

   clk_gate_ctrl #(
      .IDLE_W   (8),
      .WAKE_CYC (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .en_cfg    (en_cfg),
      .idle_thr  (idle_thr),
      .test_en   (test_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .busy      (busy),
      .gate_en   (gate_en),
      .gated     (gated)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one cycle of inputs and queues the outputs expected during that cycle.
   task automatic applyStimulus(input logic rst, input logic rv, input logic bz,
                                input logic en, input logic te, input logic chk,
                                input logic eg, input logic er);
      exp_t e;
      @(posedge clock);
      #1;
      reset     = rst;
      req_valid = rv;
      busy      = bz;
      en_cfg    = en;
      test_en   = te;
      idle_thr  = thr_v;
      if (chk) begin
         e.exp_gate  = eg;
         e.exp_ready = er;
         e.vec_id    = 16'(vec_id);
         exp_q.push_back(e);
      end
      vec_id++;
   endtask

   task automatic idleCycles(input int n, input logic eg, input logic er);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, eg, er);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (gate_en !== e.exp_gate) begin
         errors++;
         $display("[TB] FAIL gate_en vec %0d got %b want %b", e.vec_id, gate_en, e.exp_gate);
      end
      checks++;
      if (gated !== !e.exp_gate) begin
         errors++;
         $display("[TB] FAIL gated vec %0d got %b want %b", e.vec_id, gated, !e.exp_gate);
      end
      checks++;
      if (req_ready !== e.exp_ready) begin
         errors++;
         $display("[TB] FAIL req_ready vec %0d got %b want %b", e.vec_id, req_ready, e.exp_ready);
      end
   endtask

   // Outputs settle after the posedge; sampling mid-cycle keeps checks off the edge.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      vec_id    = 0;
      thr_v     = 8'd3;
      reset     = 1'b1;
      req_valid = 1'b0;
      busy      = 1'b0;
      en_cfg    = 1'b1;
      test_en   = 1'b0;
      idle_thr  = 8'd3;

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

      // thr=3: five idle cycles, clock off from the sixth
      idleCycles(5, 1'b1, 1'b1);
      idleCycles(2, 1'b0, 1'b0);

      // request in OFF: ready returns WAKE_CYC+1 cycles later
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b1, 1'b0);

      // three idle cycles, a request, then the full count restarts
      idleCycles(3, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idleCycles(1, 1'b1, 1'b1);
      thr_v = 8'd0;
      idleCycles(4, 1'b1, 1'b1);
      idleCycles(1, 1'b0, 1'b0);

      // test_en wakes from OFF
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b1, 1'b0);

      // thr=0: OFF after two idle cycles, busy on the first OFF cycle wakes
      idleCycles(2, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b1, 1'b0);

      // en_cfg=0 wakes from OFF
      idleCycles(2, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b1, 1'b0);

      // gating inhibited by test_en, then by en_cfg=0, with no traffic
      for (int i = 0; i < 150; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      for (int i = 0; i < 150; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      end

      // reset mid-IDLE restarts the full idle count
      thr_v = 8'd3;
      idleCycles(2, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idleCycles(5, 1'b1, 1'b1);
      idleCycles(1, 1'b0, 1'b0);

      // reset mid-WAKE gives RUN immediately
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clock);
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8, width of the idle threshold and the idle counter.
REQ-002 Parameter WAKE_CYC, default 2, legal 1..15, number of cycles the clock is ungated before requests are accepted again.
REQ-003 Port clock, input, 1, single block clock.
REQ-004 Port reset, input, 1, synchronous, active-high.
REQ-005 Port en_cfg, input, 1, global gating enable; 0 keeps the clock on.
REQ-006 Port idle_thr, input, IDLE_W, idle-cycle threshold.
REQ-007 Port test_en, input, 1, DFT mode; inhibits gating.
REQ-008 Port req_valid, input, 1, upstream request to the gated domain.
REQ-009 Port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-010 Port busy, input, 1, gated domain has work in flight.
REQ-011 Port gate_en, output, 1, enable to the clock-gate cell E input.
REQ-012 Port gated, output, 1, status; equals !gate_en.

Function
REQ-013 The block SHALL treat a cycle as idle when !req_valid && !busy && en_cfg && !test_en.
REQ-014 FSM states SHALL be RUN, IDLE, OFF and WAKE.
REQ-015 In RUN the outputs SHALL be gate_en=1 and req_ready=1.
REQ-016 RUN SHALL move to IDLE on an idle cycle, and SHALL load cnt=idle_thr.
REQ-017 In IDLE the outputs SHALL be gate_en=1 and req_ready=1.
REQ-018 IDLE transitions SHALL be as follows:
- Non-idle cycle: go to RUN. This has priority over everything else.
- Idle cycle with cnt==0: go to OFF.
- Idle cycle with cnt!=0: cnt decrements.
REQ-019 Net idle timing: OFF SHALL be entered after idle_thr+2 consecutive idle cycles. gate_en SHALL be low in the following cycle.
REQ-020 In OFF the outputs SHALL be gate_en=0 and req_ready=0.
REQ-021 OFF SHALL move to WAKE when any of req_valid, busy, !en_cfg or test_en is true, and SHALL load cnt=WAKE_CYC-1.
REQ-022 In WAKE the outputs SHALL be gate_en=1 and req_ready=0.
REQ-023 WAKE SHALL go to RUN when cnt==0, otherwise cnt decrements. WAKE SHALL ignore idle and non-idle conditions until complete.
REQ-024 A request sampled in OFF at cycle t SHALL see req_ready=1 at cycle t+WAKE_CYC+1.
REQ-025 gate_en and gated SHALL be driven directly from flops, with no combinational path from any input. This keeps the value glitch-free for the latch inside the gate cell.
REQ-026 req_ready SHALL be decoded from state only.
REQ-027 A change of idle_thr SHALL take effect only at the next RUN->IDLE load.
REQ-028 An idle_thr value of 0 SHALL give OFF after exactly 2 idle cycles.

Reset
REQ-029 On reset the block SHALL set state=RUN, cnt=0, gate_en=1, gated=0 and req_ready=1, so the clock is on out of reset.
REQ-030 Reset asserted in any state, including mid-WAKE and mid-IDLE, SHALL return the block to RUN on the next clock edge, with no wake delay.

Structure
REQ-031 Package clk_gate_ctrl_pkg SHALL hold the following:
- The state enum, 2-bit: RUN=0, IDLE=1, OFF=2, WAKE=3.
- Default constants for IDLE_W and WAKE_CYC.
REQ-032 A single shared loadable down-counter sub-module clk_gate_ctrl_cnt SHALL serve both IDLE and WAKE.
- Ports: load, load_val, dec, zero.
- Width: max(IDLE_W,4).

Verification
REQ-033 Scenario: idle_thr=3, en_cfg=1, all other inputs 0 for 5 cycles -> gate_en=0 and gated=1 from cycle 6.
REQ-034 Scenario: idle_thr=3, and req_valid pulses on idle cycle 4 -> return to RUN, gate_en stays 1, and the full 5-cycle count restarts.
REQ-035 Scenario: in OFF, req_valid=1 at cycle t with WAKE_CYC=2 -> gate_en=1 at t+1, req_ready=0 at t+1 and t+2, req_ready=1 at t+3.
REQ-036 Scenario: test_en=1 or en_cfg=0 held with idle traffic for 300 cycles -> gate_en never drops. The same inputs asserted in OFF -> WAKE then RUN.
REQ-037 Scenario: reset asserted during WAKE and during IDLE -> next cycle state=RUN, gate_en=1, req_ready=1.
REQ-038 Scenario: idle_thr=0 -> OFF after 2 idle cycles. busy=1 in the same cycle as OFF entry -> WAKE next cycle.
